// File: rtl/dma_line_arbiter.sv
// Two-requester cache-line arbiter that serialises icache/dcache fills and write-backs onto one DMA engine.
// Optional watchdog enabled by defining DMA_LINE_ARBITER_TIMEOUT_EN.
module dma_line_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_we,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    output logic [1:0]                req_grant,
    output logic [1:0]                resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_data,
    output logic                      busy,
    output logic                      err,
    output logic [ADDR_WIDTH-1:0]     dma_rd_addr,
    output logic [ADDR_WIDTH-1:0]     dma_wr_addr,
    output logic [ADDR_WIDTH-6:0]     dma_rd_size,
    output logic [ADDR_WIDTH-6:0]     dma_wr_size,
    output logic                      dma_rd_go,
    output logic                      dma_wr_go,
    output logic                      dma_rd_en,
    output logic                      dma_wr_en,
    input  logic [DATA_WIDTH-1:0]     dma_rd_data,
    input  logic                      dma_empty,
    input  logic                      dma_rd_done,
    input  logic                      dma_full,
    input  logic                      dma_wr_done,
    output logic [DATA_WIDTH-1:0]     dma_wr_data
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_GO   = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] RD_FIN  = 3'd3;
    localparam logic [2:0] WR_GO   = 3'd4;
    localparam logic [2:0] WR_PUSH = 3'd5;
    localparam logic [2:0] WR_FIN  = 3'd6;

    logic [2:0]            state;
    logic                  last_grant;
    logic                  owner;
    logic                  pick;
    logic                  grant_any;
    logic                  timed_out;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        pick = 1'b0;
        if (req_valid == 2'b11) begin
            pick = ~last_grant;
        end else begin
            pick = req_valid[1];
        end
    end

    assign grant_any = rst_n && (state == IDLE) && (req_valid != 2'b00);
    assign req_grant = grant_any ? (pick ? 2'b10 : 2'b01) : 2'b00;

    assign busy        = (state != IDLE);
    assign dma_rd_go   = (state == RD_GO);
    assign dma_wr_go   = (state == WR_GO);
    assign dma_rd_en   = (state == RD_WAIT) && !dma_empty && !timed_out;
    assign dma_wr_en   = (state == WR_PUSH) && !dma_full && !timed_out;
    assign dma_rd_addr = lat_addr;
    assign dma_wr_addr = lat_addr;
    assign dma_wr_data = lat_wdata;
    assign dma_rd_size = {{(ADDR_WIDTH-6){1'b0}}, 1'b1};
    assign dma_wr_size = {{(ADDR_WIDTH-6){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_data  <= '0;
            resp_valid <= 2'b00;
        end else begin
            resp_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner      <= pick;
                        last_grant <= pick;
                        lat_addr   <= pick ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
                        lat_wdata  <= pick ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
                        state      <= req_we[pick] ? WR_GO : RD_GO;
                    end
                end
                RD_GO:   state <= RD_WAIT;
                RD_WAIT: begin
                    if (!dma_empty) begin
                        resp_data <= dma_rd_data;
                        state     <= RD_FIN;
                    end
                end
                // Only reachable after rd_en, so a done left over from an earlier transfer cannot complete this one early.
                RD_FIN: begin
                    if (dma_rd_done) begin
                        resp_valid <= owner ? 2'b10 : 2'b01;
                        state      <= IDLE;
                    end
                end
                WR_GO:   state <= WR_PUSH;
                WR_PUSH: begin
                    if (!dma_full) begin
                        state <= WR_FIN;
                    end
                end
                WR_FIN: begin
                    if (dma_wr_done) begin
                        resp_valid <= owner ? 2'b10 : 2'b01;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (timed_out) begin
                resp_valid <= 2'b00;
                state      <= IDLE;
            end
        end
    end

`ifdef DMA_LINE_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wd_count;
    logic             waiting;

    // Counts every cycle since the grant, so the registered err lands exactly TIMEOUT_CYCLES after it.
    assign waiting   = (state == RD_WAIT) || (state == RD_FIN) || (state == WR_PUSH) || (state == WR_FIN);
    assign timed_out = waiting && (wd_count == CNT_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_count <= '0;
            err      <= 1'b0;
        end else begin
            err <= timed_out;
            if (grant_any) begin
                wd_count <= '0;
            end else if (busy && !timed_out) begin
                wd_count <= wd_count + 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign timed_out      = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_dma_line_arbiter.sv
// Self-checking bench for dma_line_arbiter: a behavioural DMA responder plus a transaction-level
// reference model (round-robin choice, latency = 4 + DMA stall cycles, expected data).
module tb_dma_line_arbiter;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [2*AW-1:0]   req_addr;
    logic [2*DW-1:0]   req_wdata;
    logic [1:0]        req_grant;
    logic [1:0]        resp_valid;
    logic [DW-1:0]     resp_data;
    logic              busy;
    logic              err;
    logic [AW-1:0]     dma_rd_addr;
    logic [AW-1:0]     dma_wr_addr;
    logic [AW-6:0]     dma_rd_size;
    logic [AW-6:0]     dma_wr_size;
    logic              dma_rd_go;
    logic              dma_wr_go;
    logic              dma_rd_en;
    logic              dma_wr_en;
    logic [DW-1:0]     dma_rd_data = '0;
    logic              dma_empty = 1'b1;
    logic              dma_rd_done = 1'b0;
    logic              dma_full = 1'b1;
    logic              dma_wr_done = 1'b0;
    logic [DW-1:0]     dma_wr_data;

    dma_line_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_grant(req_grant), .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(busy), .err(err),
        .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr),
        .dma_rd_size(dma_rd_size), .dma_wr_size(dma_wr_size),
        .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go), .dma_rd_en(dma_rd_en), .dma_wr_en(dma_wr_en),
        .dma_rd_data(dma_rd_data), .dma_empty(dma_empty), .dma_rd_done(dma_rd_done),
        .dma_full(dma_full), .dma_wr_done(dma_wr_done), .dma_wr_data(dma_wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int errors = 0;
    int checks = 0;

    // DMA behaviour knobs, written only by the stimulus block
    int          rd_delay = 0;
    int          full_delay = 0;
    int          done_delay = 0;
    bit          stuck_done = 1'b0;
    logic [DW-1:0] dma_line = '0;

    // Responder bookkeeping, written only by the responder process
    bit          rd_armed = 0, wr_armed = 0, rd_due = 0, wr_due = 0;
    int          rd_wait = 0, wr_wait = 0, rd_due_wait = 0, wr_due_wait = 0;
    int          rd_en_cnt = 0, wr_en_cnt = 0, bad_en_cnt = 0;
    logic [AW-1:0] seen_rd_addr = '0, seen_wr_addr = '0;
    logic [DW-1:0] seen_wr_data = '0;

    // Observes strobes mid-cycle, then drives the DMA inputs just after the next rising edge.
    always begin
        @(negedge clk);
        if (!rst_n) begin
            rd_armed = 0; wr_armed = 0; rd_due = 0; wr_due = 0;
        end else begin
            if (dma_rd_go) begin rd_armed = 1; rd_wait = rd_delay; seen_rd_addr = dma_rd_addr; end
            if (dma_rd_en) begin
                if (dma_empty) bad_en_cnt++;
                rd_armed = 0; rd_en_cnt++; rd_due = 1; rd_due_wait = done_delay;
            end
            if (dma_wr_go) begin wr_armed = 1; wr_wait = full_delay; seen_wr_addr = dma_wr_addr; end
            if (dma_wr_en) begin
                if (dma_full) bad_en_cnt++;
                wr_armed = 0; wr_en_cnt++; seen_wr_data = dma_wr_data; wr_due = 1; wr_due_wait = done_delay;
            end
        end
        @(posedge clk);
        #1;
        dma_empty = 1'b1;
        if (rd_armed) begin
            if (rd_wait > 0) rd_wait--;
            else begin dma_empty = 1'b0; dma_rd_data = dma_line; end
        end
        dma_rd_done = stuck_done;
        if (rd_due) begin
            if (rd_due_wait > 0) rd_due_wait--;
            else begin dma_rd_done = 1'b1; rd_due = 0; end
        end
        dma_full = 1'b1;
        if (wr_armed) begin
            if (wr_wait > 0) wr_wait--;
            else dma_full = 1'b0;
        end
        dma_wr_done = 1'b0;
        if (wr_due) begin
            if (wr_due_wait > 0) wr_due_wait--;
            else begin dma_wr_done = 1'b1; wr_due = 0; end
        end
    end

    // Reference model state
    int            last_idx = 1;
    int            cur_idx = 0;
    bit            cur_we = 0;
    bit            pending = 0;
    int            grant_cyc = 0;
    int            exp_lat = 0;
    int            rd_en0 = 0, wr_en0 = 0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic [DW-1:0] exp_line = '0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [1:0] v);
        if (v == 2'b11) return (last_idx == 0) ? 1 : 0;
        return v[1] ? 1 : 0;
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] l;
        for (int i = 0; i < DW/32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Runs cycles until n_resp completions are seen, checking every grant and completion against the model.
    task automatic serve(input int n_resp, input bit hold);
        int got = 0;
        int spent = 0;
        int e;
        logic [1:0] drop;
        while (got < n_resp && spent < 300) begin
            @(negedge clk);
            spent++;
            drop = 2'b00;
            check("rd_wr_exclusive", DW'((dma_rd_go | dma_rd_en) & (dma_wr_go | dma_wr_en)), '0);
            if (resp_valid !== 2'b00) begin
                check("resp_valid", DW'(resp_valid), pending ? DW'(2'b01 << cur_idx) : '0);
                check("latency", DW'(cyc - grant_cyc), DW'(exp_lat));
                if (cur_we) begin
                    check("wr_data", seen_wr_data, cur_wdata);
                    check("wr_addr", DW'(seen_wr_addr), DW'(cur_addr));
                    check("wr_en_count", DW'(wr_en_cnt - wr_en0), DW'(1));
                    check("rd_en_none", DW'(rd_en_cnt - rd_en0), '0);
                end else begin
                    check("resp_data", resp_data, exp_line);
                    check("rd_addr", DW'(seen_rd_addr), DW'(cur_addr));
                    check("rd_en_count", DW'(rd_en_cnt - rd_en0), DW'(1));
                    check("wr_en_none", DW'(wr_en_cnt - wr_en0), '0);
                end
                check("en_while_blocked", DW'(bad_en_cnt), '0);
                pending = 0;
                got++;
            end
            if (req_grant !== 2'b00) begin
                e = model_pick(req_valid);
                check("grant", DW'(req_grant), DW'(2'b01 << e));
                check("busy_at_grant", DW'(busy), '0);
                check("grant_while_pending", DW'(pending), '0);
                last_idx  = e;
                cur_idx   = e;
                cur_we    = req_we[e];
                cur_addr  = req_addr[e*AW +: AW];
                cur_wdata = req_wdata[e*DW +: DW];
                exp_line  = dma_line;
                grant_cyc = cyc;
                rd_en0    = rd_en_cnt;
                wr_en0    = wr_en_cnt;
                exp_lat   = cur_we ? 4 + full_delay + done_delay
                                   : 4 + rd_delay + (stuck_done ? 0 : done_delay);
                pending   = 1;
                if (!hold) drop[e] = 1'b1;
            end
            @(posedge clk);
            #1;
            req_valid = req_valid & ~drop;
        end
        if (got < n_resp) check("resp_timeout", DW'(got), DW'(n_resp));
    endtask

    initial begin
        int err_at;
        int resp_seen;
        int e;
        logic busy_at_err;
        logic [1:0] v;

        rst_n = 1'b0;
        req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b11;
        @(negedge clk);
        check("rst_grant", DW'(req_grant), '0);
        check("rst_resp_valid", DW'(resp_valid), '0);
        check("rst_busy", DW'(busy), '0);
        check("rst_err", DW'(err), '0);
        check("rst_strobes", DW'({dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}), '0);
        check("rst_rd_size", DW'(dma_rd_size), DW'(1));
        check("rst_wr_size", DW'(dma_wr_size), DW'(1));
        check("rst_resp_data", resp_data, '0);
        check("rst_wr_data", dma_wr_data, '0);
        check("rst_addrs", DW'({dma_rd_addr, dma_wr_addr}), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 2'b00;
        last_idx = 1;

        // icache fill at 0x1000, DMA offers the line two cycles late
        rd_delay = 2; done_delay = 0;
        dma_line = {(DW/8){8'hA5}};
        req_we = 2'b00; req_addr[AW-1:0] = 64'h1000; req_valid = 2'b01;
        serve(1, 1'b0);

        // both caches hammer fills; grants must alternate
        rd_delay = 0;
        dma_line = rand_line();
        req_addr = {64'h0000_0000_0000_8000, 64'h0000_0000_0000_4000};
        req_valid = 2'b11;
        serve(4, 1'b1);
        req_valid = 2'b00;
        serve(1, 1'b0);

        // dcache write-back to 0x2040 against a full DMA FIFO
        full_delay = 10;
        req_we = 2'b10; req_addr[2*AW-1:AW] = 64'h2040; req_wdata[2*DW-1:DW] = rand_line();
        req_valid = 2'b10;
        serve(1, 1'b0);
        full_delay = 0;

        // rd_done stuck high: completion may not come before the read strobe
        stuck_done = 1'b1; rd_delay = 3;
        dma_line = rand_line();
        req_we = 2'b00; req_addr[AW-1:0] = 64'h5000; req_valid = 2'b01;
        serve(1, 1'b0);
        stuck_done = 1'b0; rd_delay = 0;

        // DMA never offers data: watchdog (when built in) or indefinite wait
        rd_delay = 100000;
        req_we = 2'b00; req_addr[AW-1:0] = 64'h3000; req_valid = 2'b01;
        @(negedge clk);
        e = model_pick(req_valid);
        check("grant_stall", DW'(req_grant), DW'(2'b01 << e));
        last_idx = e;
        grant_cyc = cyc;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        err_at = -1; busy_at_err = 1'b1; resp_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (err === 1'b1 && err_at < 0) begin err_at = cyc - grant_cyc; busy_at_err = busy; end
            if (resp_valid !== 2'b00) resp_seen++;
            @(posedge clk);
            #1;
        end
`ifdef DMA_LINE_ARBITER_TIMEOUT_EN
        check("err_cycle", DW'(err_at), DW'(TO));
        check("idle_after_err", DW'(busy_at_err), '0);
`else
        check("err_never", DW'(err_at), DW'(-1));
        check("still_waiting", DW'(busy), DW'(1));
`endif
        check("no_resp_on_stall", DW'(resp_seen), '0);
        rd_delay = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_idx = 1;

        // reset while waiting for rd_done abandons the transfer silently
        done_delay = 4;
        dma_line = rand_line();
        req_we = 2'b00; req_addr[AW-1:0] = 64'h6000; req_valid = 2'b01;
        @(negedge clk);
        check("grant_pre_reset", DW'(req_grant), DW'(2'b01));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 2'b01;
        #1;
        check("reset_busy", DW'(busy), '0);
        check("reset_grant", DW'(req_grant), '0);
        check("reset_resp_data", resp_data, '0);
        check("reset_rd_addr", DW'(dma_rd_addr), '0);
        resp_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid !== 2'b00) resp_seen++;
        end
        check("reset_no_resp", DW'(resp_seen), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 2'b00;
        last_idx = 1;
        done_delay = 0;
        req_we = 2'b00;
        req_addr = {64'h0000_0000_0000_7040, 64'h0000_0000_0000_7000};
        req_valid = 2'b11;
        serve(2, 1'b0);

        // randomized mix of fills and write-backs with random DMA stalls
        for (int t = 0; t < 12; t++) begin
            v = 2'($urandom_range(1, 3));
            req_we = 2'($urandom);
            req_addr = {$urandom, $urandom, $urandom, $urandom};
            req_wdata = {rand_line(), rand_line()};
            dma_line = rand_line();
            rd_delay = $urandom_range(0, 3);
            full_delay = $urandom_range(0, 3);
            done_delay = $urandom_range(0, 2);
            req_valid = v;
            serve((v == 2'b11) ? 2 : 1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
